// File: rtl/fir_stream_feeder_pkg.sv
`default_nettype none
// ============================================================================
// fir_stream_feeder_pkg : register map, ctrl bit positions and FSM encoding
// Revision: 1.0
// ============================================================================
package fir_stream_feeder_pkg;

    localparam int unsigned REG_CTRL   = 32'h00;
    localparam int unsigned REG_LENGTH = 32'h10;
    localparam int unsigned REG_BASE   = 32'h14;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_DONE_BIT  = 1;
    localparam int CTRL_IDLE_BIT  = 2;

    localparam int LEN_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } feed_state_e;

endpackage
`default_nettype wire

// File: rtl/fir_feed_skid.sv
`default_nettype none
// ============================================================================
// fir_feed_skid : 2-entry valid/ready buffer, entry 0 is always the head
// Revision: 1.0
// ============================================================================
module fir_feed_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             push_last_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic [1:0]       count_o
);

    logic [WIDTH:0] e0_q, e0_d, e1_q, e1_d, in_w;
    logic [1:0]     cnt_q, cnt_d;
    logic           pop;

    assign in_w = {push_last_i, push_data_i};
    assign pop  = (cnt_q != 2'd0) && ready_i;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push_i, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    e0_d  = in_w;
                    cnt_d = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    e1_d  = in_w;
                    cnt_d = 2'd2;
                end
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the new word lands behind whatever remains.
                if (cnt_q == 2'd1) begin
                    e0_d = in_w;
                end else begin
                    e0_d = e1_q;
                    e1_d = in_w;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = e0_q[WIDTH-1:0];
    assign last_o  = valid_o & e0_q[WIDTH];
    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fir_stream_feeder.sv
`default_nettype none
// ============================================================================
// fir_stream_feeder : AXI-Lite controlled streamer from sample RAM to AXI-Stream
// Revision: 1.0
// ============================================================================
module fir_stream_feeder
    import fir_stream_feeder_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   awready,
    input  logic                   wvalid,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   wready,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arready,
    input  logic                   rready,
    output logic                   rvalid,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic                   src_EN,
    output logic [pADDR_WIDTH-1:0] src_A,
    input  logic [pDATA_WIDTH-1:0] src_Do
);

    feed_state_e            state_q, state_d;
    logic                   aw_rdy_q, ar_rdy_q, rvalid_q;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [LEN_W-1:0]       length_q, issued_q;
    logic [pADDR_WIDTH-1:0] base_q;
    logic                   done_q, done_d;
    logic                   inflight_q, inflight_last_q;
    logic                   wr_hs, rd_hs, start_acc, last_acc, issue, pop, room;
    logic [1:0]             occ;
    logic [2:0]             credit;
    logic                   skid_valid, skid_last;
    logic [pDATA_WIDTH-1:0] skid_data;

    assign wr_hs     = aw_rdy_q & awvalid & wvalid;
    assign rd_hs     = ar_rdy_q & arvalid;
    assign start_acc = wr_hs && (awaddr == pADDR_WIDTH'(REG_CTRL)) &&
                       wdata[CTRL_START_BIT] && (state_q == ST_IDLE);

    assign pop      = skid_valid & m_tready;
    assign last_acc = pop & skid_last;

    // A beat leaving the buffer this cycle frees a slot, keeping one beat per cycle.
    assign credit = {1'b0, occ} + {2'b00, inflight_q};
    assign room   = pop ? (credit < 3'd3) : (credit < 3'd2);
    assign issue  = (state_q == ST_RUN) && (issued_q != length_q) && room;

    assign src_EN = issue;
    assign src_A  = issue ? base_q + {issued_q[pADDR_WIDTH-3:0], 2'b00} : '0;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_hs) begin
            rdata_d = '0;
            if (araddr == pADDR_WIDTH'(REG_CTRL)) begin
                rdata_d[CTRL_DONE_BIT] = done_q;
                rdata_d[CTRL_IDLE_BIT] = (state_q == ST_IDLE);
            end else if (araddr == pADDR_WIDTH'(REG_LENGTH)) begin
                rdata_d = pDATA_WIDTH'(length_q);
            end else if (araddr == pADDR_WIDTH'(REG_BASE)) begin
                rdata_d = pDATA_WIDTH'(base_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: if (start_acc && (length_q != '0)) state_d = ST_RUN;
            ST_RUN:  if (last_acc) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Setting wins: a ctrl read on the final-beat edge returned the old value.
        if ((rd_hs && (araddr == pADDR_WIDTH'(REG_CTRL))) || start_acc) done_d = 1'b0;
        if (last_acc || (start_acc && (length_q == '0))) done_d = 1'b1;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q         <= ST_IDLE;
            done_q          <= 1'b0;
            aw_rdy_q        <= 1'b0;
            ar_rdy_q        <= 1'b0;
            rvalid_q        <= 1'b0;
            rdata_q         <= '0;
            length_q        <= '0;
            base_q          <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            aw_rdy_q <= awvalid & wvalid & ~aw_rdy_q;
            ar_rdy_q <= arvalid & ~ar_rdy_q & ~rvalid_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
            rdata_q <= rdata_d;
            if (wr_hs && (state_q == ST_IDLE)) begin
                if (awaddr == pADDR_WIDTH'(REG_LENGTH)) length_q <= wdata[LEN_W-1:0];
                if (awaddr == pADDR_WIDTH'(REG_BASE))   base_q   <= wdata[pADDR_WIDTH-1:0];
            end
            if (start_acc) begin
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + 1'b1;
            end
            inflight_q      <= issue;
            inflight_last_q <= issue && (issued_q == length_q - 1'b1);
        end
    end

    fir_feed_skid #(
        .WIDTH(pDATA_WIDTH)
    ) u_skid (
        .clk_i      (axis_clk),
        .rst_ni     (axis_rst_n),
        .push_i     (inflight_q),
        .push_data_i(src_Do),
        .push_last_i(inflight_last_q),
        .ready_i    (m_tready),
        .valid_o    (skid_valid),
        .data_o     (skid_data),
        .last_o     (skid_last),
        .count_o    (occ)
    );

    assign awready  = aw_rdy_q;
    assign wready   = aw_rdy_q;
    assign arready  = ar_rdy_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign m_tvalid = skid_valid;
    assign m_tdata  = skid_data;
    assign m_tlast  = skid_last;

endmodule
`default_nettype wire

// File: doc/fir_stream_feeder.md
FIR_STREAM_FEEDER -- requirements
Module: fir_stream_feeder

Interface
REQ-001 Parameter pADDR_WIDTH, default 12, width of AXI-Lite and sample-RAM addresses.
REQ-002 Parameter pDATA_WIDTH, default 32, sample and register data width.
REQ-003 One clock; reset is asynchronous and active-low: axis_clk  input  1  sole clock, all logic on rising edge.
REQ-004 axis_rst_n  input  1  asynchronous active-low reset.
REQ-005 awvalid/awaddr  input  1/pADDR_WIDTH  AXI-Lite write address; awready  output  1.
REQ-006 wvalid/wdata  input  1/pDATA_WIDTH  AXI-Lite write data; wready  output  1.
REQ-007 arvalid/araddr  input  1/pADDR_WIDTH  AXI-Lite read address; arready  output  1.
REQ-008 rready  input  1; rvalid/rdata  output  1/pDATA_WIDTH  AXI-Lite read data.
REQ-009 m_tvalid/m_tdata/m_tlast  output  1/pDATA_WIDTH/1  AXI-Stream master, drives FIR ss_* inputs.
REQ-010 m_tready  input  1  downstream (FIR ss_tready) acceptance.
REQ-011 src_EN  output  1, src_A  output  pADDR_WIDTH  sample-RAM read port (byte address); src_Do  input  pDATA_WIDTH, valid one cycle after src_EN.

Function
REQ-012 Registers: 0x00 ctrl (bit0 ap_start W1, bit1 ap_done, bit2 ap_idle), 0x10 length (32 b), 0x14 base byte address; unmapped reads return 0, unmapped writes ignored.
REQ-013 Write: awready and wready SHALL pulse together for exactly one cycle when awvalid and wvalid are both high; write takes effect on that edge.
REQ-014 Read: arready pulses one cycle on arvalid; rvalid rises next cycle with rdata, held stable until rready.
REQ-015 FSM states IDLE, RUN, DONE; IDLE->RUN on accepted write of bit0=1 to 0x00 with length>0; RUN->DONE when beat with m_tlast is accepted; DONE->IDLE next cycle.
REQ-016 ap_start with length=0: no beats, ap_done set, FSM returns to IDLE.
REQ-017 ap_start, 0x10 and 0x14 writes SHALL be ignored outside IDLE.
REQ-018 ap_idle=1 only in IDLE; ap_done set on final beat acceptance, cleared by the read of 0x00 that returned it or by a new ap_start.
REQ-019 Beat i reads src_A = base + 4*i, modulo 2^pADDR_WIDTH (wraps silently).
REQ-020 2-entry output buffer absorbs 1-cycle RAM latency; read issued only if buffered + in-flight < 2; no beat lost or duplicated.
REQ-021 First m_tvalid no later than 3rd rising edge after ap_start write edge; with m_tready held high, one beat per cycle sustained.
REQ-022 m_tdata/m_tlast SHALL be stable while m_tvalid high and m_tready low; m_tvalid never drops without acceptance.
REQ-023 m_tlast=1 exactly on beat length-1; length counter 32 b, beat counter compared unsigned.
REQ-024 Simultaneous read and write of 0x00 on the same edge: read returns pre-write value.

Reset
REQ-025 Async assert: all FSM/buffer state cleared, in-flight beats abandoned; outputs awready=wready=arready=rvalid=0, rdata=0, m_tvalid=m_tlast=0, m_tdata=0, src_EN=0, src_A=0.
REQ-026 Registers reset to length=0, base=0, ap_start=0, ap_done=0, ap_idle=1; operation resumes in IDLE after synchronous deassertion edge.

Structure
REQ-027 Shared package holds register offsets (0x00, 0x10, 0x14), ctrl bit indices and FSM state encoding, reused by the FIR block.
REQ-028 One sub-module, fir_feed_skid (2-entry valid/ready buffer); AXI-Lite decode and FSM in top.

Verification
REQ-029 length=4, base=0x040, RAM {5,-3,7,9}, m_tready=1 -> beats 5,-3,7,9 consecutive, m_tlast on 9, ap_done read =1 then 0.
REQ-030 length=600, m_tready random 50% -> 600 beats in order, none lost/duplicated, 0x00 reads 0x6 after done then 0x4.
REQ-031 length=0, ap_start -> no m_tvalid, 0x00 reads ap_done=1, ap_idle=1.
REQ-032 base=0xFF8 (pADDR_WIDTH=12), length=4 -> src_A 0xFF8,0xFFC,0x000,0x004.
REQ-033 Write length=8 then ap_start again mid-run (length=4) -> ignored, exactly 4 beats, length reads 4.
REQ-034 axis_rst_n low during beat 2 of 10 -> m_tvalid=0 immediately, 0x00 reads 0x4; fresh ap_start streams from beat 0.
